// File: rtl/bus_cycle_arbiter.sv
// bus_cycle_arbiter: round-robin two-requester 8086-style bus cycle sequencer with wait-state timeout
module bus_cycle_arbiter #(
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [1:0]  req,
  input  logic        req_wr_0,
  input  logic        req_wr_1,
  input  logic        req_iom_0,
  input  logic        req_iom_1,
  input  logic [19:0] req_addr_0,
  input  logic [19:0] req_addr_1,
  input  logic [7:0]  req_wdata_0,
  input  logic [7:0]  req_wdata_1,
  output logic [1:0]  gnt,
  output logic [1:0]  done,
  output logic        err,
  output logic [7:0]  rdata,
  output logic        ALE,
  output logic        CS,
  output logic        IOM,
  output logic        RD,
  output logic        WR,
  output logic [19:0] Address,
  output logic [7:0]  Data_out,
  output logic        data_oe,
  input  logic [7:0]  Data_in,
  input  logic        READY
);
  typedef enum logic [2:0] {IDLE, T1, T2, T3, TW, T4} state_t;
  state_t state, state_d;
  logic owner, owner_d, last, last_d, cyc_wr, cyc_wr_d, iom_d, ale_d, cs_d, rd_d, wr_d, oe_d, err_d, finish;
  logic [1:0] gnt_d, done_d;
  logic [19:0] addr_d;
  logic [7:0] wdata_d, rdata_d;
  logic [WAIT_W-1:0] cnt, cnt_d;
  assign finish = READY || (state == TW && cnt == WAIT_W'(MAX_WAIT));
  // next-state and next-output logic; every output is registered from these values
  always_comb begin
    state_d = state;
    owner_d = owner;
    last_d = last;
    cyc_wr_d = cyc_wr;
    iom_d = IOM;
    addr_d = Address;
    wdata_d = Data_out;
    rdata_d = rdata;
    cnt_d = cnt;
    ale_d = 1'b0;
    cs_d = 1'b0;
    rd_d = 1'b1;
    wr_d = 1'b1;
    oe_d = 1'b0;
    gnt_d = 2'b00;
    done_d = 2'b00;
    err_d = 1'b0;
    case (state)
      IDLE: if (|req) begin
        owner_d = &req ? ~last : req[1];
        cyc_wr_d = owner_d ? req_wr_1 : req_wr_0;
        iom_d = owner_d ? req_iom_1 : req_iom_0;
        addr_d = owner_d ? req_addr_1 : req_addr_0;
        wdata_d = owner_d ? req_wdata_1 : req_wdata_0;
        gnt_d = owner_d ? 2'b10 : 2'b01;
        ale_d = 1'b1;
        cs_d = 1'b1;
        cnt_d = '0;
        state_d = T1;
      end
      T1, T2: begin
        state_d = (state == T1) ? T2 : T3;
        cs_d = 1'b1;
        {rd_d, wr_d, oe_d} = {cyc_wr, ~cyc_wr, cyc_wr};
      end
      T3, TW: begin
        cs_d = 1'b1;
        if (finish) begin
          state_d = T4;
          done_d = owner ? 2'b10 : 2'b01;
          err_d = ~READY;
          rdata_d = (READY && !cyc_wr) ? Data_in : rdata;
        end else begin
          state_d = TW;
          cnt_d = (state == T3) ? WAIT_W'(1) : cnt + 1'b1;
          {rd_d, wr_d, oe_d} = {cyc_wr, ~cyc_wr, cyc_wr};
        end
      end
      T4: begin
        state_d = IDLE;
        last_d = owner;
        cnt_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and output registers; reset forces strobes inactive immediately
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
      owner <= 1'b0;
      last <= 1'b1;
      cyc_wr <= 1'b0;
      cnt <= '0;
      ALE <= 1'b0;
      CS <= 1'b0;
      IOM <= 1'b0;
      RD <= 1'b1;
      WR <= 1'b1;
      Address <= '0;
      Data_out <= '0;
      data_oe <= 1'b0;
      gnt <= 2'b00;
      done <= 2'b00;
      err <= 1'b0;
      rdata <= '0;
    end else begin
      state <= state_d;
      owner <= owner_d;
      last <= last_d;
      cyc_wr <= cyc_wr_d;
      cnt <= cnt_d;
      ALE <= ale_d;
      CS <= cs_d;
      IOM <= iom_d;
      RD <= rd_d;
      WR <= wr_d;
      Address <= addr_d;
      Data_out <= wdata_d;
      data_oe <= oe_d;
      gnt <= gnt_d;
      done <= done_d;
      err <= err_d;
      rdata <= rdata_d;
    end
  end
endmodule

// File: tb/tb_bus_cycle_arbiter.sv
// tb_bus_cycle_arbiter: vector table, corner sequences and random traffic against a phase-count bus model
module tb_bus_cycle_arbiter;
  localparam int MAX_WAIT = 15;
  logic CLK = 1'b0, RESET = 1'b0, READY = 1'b1;
  logic [1:0] req = 2'b00;
  logic req_wr_0 = 1'b0, req_wr_1 = 1'b0, req_iom_0 = 1'b0, req_iom_1 = 1'b0;
  logic [19:0] req_addr_0 = '0, req_addr_1 = '0;
  logic [7:0] req_wdata_0 = '0, req_wdata_1 = '0, Data_in = '0;
  logic [1:0] gnt, done;
  logic err, ALE, CS, IOM, RD, WR, data_oe;
  logic [7:0] rdata, Data_out;
  logic [19:0] Address;

  bus_cycle_arbiter #(.MAX_WAIT(MAX_WAIT), .WAIT_W(4)) dut (
    .CLK(CLK), .RESET(RESET), .req(req),
    .req_wr_0(req_wr_0), .req_wr_1(req_wr_1), .req_iom_0(req_iom_0), .req_iom_1(req_iom_1),
    .req_addr_0(req_addr_0), .req_addr_1(req_addr_1), .req_wdata_0(req_wdata_0), .req_wdata_1(req_wdata_1),
    .gnt(gnt), .done(done), .err(err), .rdata(rdata), .ALE(ALE), .CS(CS), .IOM(IOM), .RD(RD), .WR(WR),
    .Address(Address), .Data_out(Data_out), .data_oe(data_oe), .Data_in(Data_in), .READY(READY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit who; bit wr; bit iom; logic [19:0] addr; logic [7:0] wd; logic [7:0] din;
    int waits; int lat; bit err; logic [7:0] rdata;
  } vec_t;
  vec_t vt[5];
  vec_t vp;

  int n_chk = 0, n_fail = 0, cyc = 0;
  // transaction-level model: cycles elapsed since the grant, and what the owner latched
  bit m_busy, m_own, m_last, m_wr, m_iom;
  int m_p, m_w, plan_w = 0;
  logic [19:0] m_addr;
  logic [7:0] m_wd, m_rdata;
  int g_cyc, d_cyc;
  bit g_own, d_own, d_err;
  logic [7:0] d_rdata;

  function automatic int m_end();
    return 3 + ((m_w > MAX_WAIT) ? MAX_WAIT : m_w);
  endfunction

  function automatic bit m_to();
    return m_w > MAX_WAIT;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic mreset();
    m_busy = 0; m_own = 0; m_last = 1; m_wr = 0; m_iom = 0;
    m_p = 0; m_w = 0; m_addr = '0; m_wd = '0; m_rdata = '0;
  endtask

  task automatic advance();
    if (!RESET) mreset();
    else if (m_busy) begin
      if (m_p == m_end()) begin
        m_busy = 0;
        m_last = m_own;
      end else begin
        if (m_p + 1 == m_end() && !m_wr && !m_to()) m_rdata = Data_in;
        m_p++;
      end
    end else if (req != 2'b00) begin
      m_own = (req == 2'b11) ? !m_last : req[1];
      m_wr = m_own ? req_wr_1 : req_wr_0;
      m_iom = m_own ? req_iom_1 : req_iom_0;
      m_addr = m_own ? req_addr_1 : req_addr_0;
      m_wd = m_own ? req_wdata_1 : req_wdata_0;
      m_w = plan_w;
      m_busy = 1;
      m_p = 0;
    end
  endtask

  task automatic check_outputs();
    logic [9:0] exp_s;
    logic [1:0] oh;
    oh = m_own ? 2'b10 : 2'b01;
    if (!m_busy) exp_s = 10'b0011000000;
    else if (m_p == 0) exp_s = {4'b1111, 1'b0, oh, 2'b00, 1'b0};
    else if (m_p < m_end()) exp_s = {2'b01, m_wr, !m_wr, m_wr, 5'b00000};
    else exp_s = {4'b0111, 1'b0, 2'b00, oh, m_to()};
    chk("strobes{ALE,CS,RD,WR,oe,gnt,done,err}", {22'd0, ALE, CS, RD, WR, data_oe, gnt, done, err}, {22'd0, exp_s});
    chk("iom_addr", {11'd0, IOM, Address}, {11'd0, m_iom, m_addr});
    chk("data_out", {24'd0, Data_out}, {24'd0, m_wd});
    chk("rdata", {24'd0, rdata}, {24'd0, m_rdata});
  endtask

  task automatic step();
    @(negedge CLK);
    cyc++;
    advance();
    check_outputs();
    if (|gnt) begin g_cyc = cyc; g_own = gnt[1]; end
    if (|done) begin d_cyc = cyc; d_own = done[1]; d_err = err; d_rdata = rdata; end
    READY = (m_busy && m_p >= 2 && m_p < m_end()) ? (m_p - 2 >= m_w) : 1'($urandom);
  endtask

  task automatic wait_gnt(input string nm);
    g_cyc = -1;
    for (int k = 0; k < 12 && g_cyc < 0; k++) step();
    chk(nm, {31'd0, g_cyc >= 0}, 32'd1);
  endtask

  task automatic wait_done(input string nm);
    d_cyc = -1;
    for (int k = 0; k < 25 && d_cyc < 0; k++) step();
    chk(nm, {31'd0, d_cyc >= 0}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int r;
    if (v.who) begin
      req_wr_1 = v.wr; req_iom_1 = v.iom; req_addr_1 = v.addr; req_wdata_1 = v.wd;
    end else begin
      req_wr_0 = v.wr; req_iom_0 = v.iom; req_addr_0 = v.addr; req_wdata_0 = v.wd;
    end
    Data_in = v.din;
    plan_w = v.waits;
    req[v.who] = 1'b1;
    r = cyc;
    d_cyc = -1;
    for (int k = 0; k < 40 && d_cyc < 0; k++) step();
    req[v.who] = 1'b0;
    chk("vec_latency", d_cyc - r, v.lat);
    chk("vec_done_owner", {31'd0, d_own}, {31'd0, v.who});
    chk("vec_err", {31'd0, d_err}, {31'd0, v.err});
    chk("vec_rdata", {24'd0, d_rdata}, {24'd0, v.rdata});
    step();
  endtask

  task automatic drain();
    req = 2'b00;
    for (int k = 0; k < 25; k++) step();
  endtask

  initial begin
    int gown[4], gt[4];
    int ng, nd;
    vt[0] = '{0, 0, 1, 20'h12345, 8'h00, 8'hA5, 0, 4, 0, 8'hA5};
    vt[1] = '{1, 1, 0, 20'hFFFFF, 8'h3C, 8'h00, 2, 6, 0, 8'hA5};
    vt[2] = '{0, 0, 0, 20'h00000, 8'h00, 8'h77, 16, 19, 1, 8'hA5};
    vt[3] = '{1, 0, 1, 20'hABCDE, 8'h00, 8'h5A, 15, 19, 0, 8'h5A};
    vt[4] = '{0, 1, 1, 20'h80001, 8'hC3, 8'h11, 1, 5, 0, 8'h5A};
    mreset();
    step();
    step();
    RESET = 1'b1;
    for (int i = 0; i < 5; i++) run_vec(vt[i]);

    RESET = 1'b0;
    step();
    RESET = 1'b1;
    req = 2'b11;
    plan_w = 0;
    ng = 0;
    nd = 0;
    for (int i = 0; i < 4; i++) begin gown[i] = -1; gt[i] = -100; end
    for (int k = 0; k < 40 && nd < 4; k++) begin
      step();
      if (|gnt && ng < 4) begin gown[ng] = int'(gnt[1]); gt[ng] = cyc; ng++; end
      if (|done) nd++;
    end
    req = 2'b00;
    chk("rr_grant_count", ng, 4);
    for (int i = 0; i < 4; i++) chk("rr_owner", gown[i], i % 2);
    for (int i = 1; i < 4; i++) chk("rr_spacing", gt[i] - gt[i-1], 5);
    step();

    req = 2'b01;
    wait_gnt("drop_gnt_seen");
    step();
    req = 2'b10;
    wait_done("drop_done_seen");
    chk("drop_done_owner", {31'd0, d_own}, 32'd0);
    wait_gnt("drop_next_gnt_seen");
    chk("drop_next_owner", {31'd0, g_own}, 32'd1);
    wait_done("drop_second_done_seen");
    req = 2'b00;
    step();

    vp = '{0, 0, 0, 20'h00042, 8'h00, 8'h99, 0, 4, 0, 8'h99};
    run_vec(vp);
    req_wr_0 = 1'b1; req_iom_0 = 1'b0; req_addr_0 = 20'h0F0F0; req_wdata_0 = 8'hE7;
    plan_w = 20;
    req = 2'b01;
    wait_gnt("abort_gnt_seen");
    for (int k = 0; k < 4; k++) step();
    chk("abort_pre_wr_low", {31'd0, WR}, 32'd0);
    #2 RESET = 1'b0;
    #1 chk("abort_async{WR,CS,oe,done}", {27'd0, WR, CS, data_oe, done}, {27'd0, 5'b10000});
    mreset();
    step();
    step();
    req = 2'b11;
    plan_w = 0;
    RESET = 1'b1;
    wait_gnt("post_reset_gnt_seen");
    chk("post_reset_owner", {31'd0, g_own}, 32'd0);
    wait_done("post_reset_done_seen");
    drain();

    for (int k = 0; k < 600; k++) begin
      req_wr_0 = 1'($urandom); req_wr_1 = 1'($urandom);
      req_iom_0 = 1'($urandom); req_iom_1 = 1'($urandom);
      req_addr_0 = 20'($urandom); req_addr_1 = 20'($urandom);
      req_wdata_0 = 8'($urandom); req_wdata_1 = 8'($urandom);
      Data_in = 8'($urandom);
      plan_w = ($urandom % 8 == 0) ? 14 + int'($urandom % 4) : int'($urandom % 3);
      for (int i = 0; i < 2; i++)
        if (req[i] && done[i]) req[i] = 1'b0;
        else if (!req[i] && $urandom % 3 == 0) req[i] = 1'b1;
      step();
    end
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bus_cycle_arbiter.md
# bus_cycle_arbiter

Two-requester bus cycle controller that shares the 8-bit / 20-bit-address memory-and-I/O bus (ALE, RD, WR, IOM, CS, Address, Data). It arbitrates round-robin between requester 0 (CPU core) and requester 1 (DMA engine), then sequences one 8086-style T1-T2-T3-(TW)-T4 bus cycle per grant. READY inserts wait states, bounded by a timeout. It sits between the core-side masters and the memory/IO slave models.

## Interface
- MAX_WAIT, 15: maximum wait states (TW cycles) before the cycle is force-terminated with err.
- WAIT_W, 4: wait counter width; must satisfy 2^WAIT_W > MAX_WAIT.

- CLK  in  1  clock; all state changes on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- req  in  2  per-requester bus request; held high until that requester's done.
- req_wr_0 / req_wr_1  in  1  1 = write cycle, 0 = read cycle.
- req_iom_0 / req_iom_1  in  1  value driven on IOM for the cycle.
- req_addr_0 / req_addr_1  in  20  cycle address.
- req_wdata_0 / req_wdata_1  in  8  write data.
- gnt  out  2  one-hot, 1-cycle pulse during T1 to the owner.
- done  out  2  one-hot, 1-cycle pulse during T4 to the owner.
- err  out  1  high with done when the cycle timed out.
- rdata  out  8  read data, valid while done is high; holds until the next read completes.
- ALE  out  1  address latch enable, high in T1 only.
- CS  out  1  chip select, high T1 through T4.
- IOM  out  1  latched req_iom of owner, valid T1 through T4.
- RD  out  1  active-low read strobe.
- WR  out  1  active-low write strobe.
- Address  out  20  latched owner address, valid T1 through T4.
- Data_out  out  8  latched write data.
- data_oe  out  1  write-data output enable.
- Data_in  in  8  read data from slave.
- READY  in  1  slave ready; low stretches the cycle.

## Operation
- States: IDLE, T1, T2, T3, TW, T4. All outputs registered.
- Reset (asynchronous, immediate): state IDLE; ALE 0, CS 0, IOM 0, RD 1, WR 1, Address 0, Data_out 0, data_oe 0, gnt 0, done 0, err 0, rdata 0; last-owner pointer = 1, so requester 0 wins first; wait counter 0.
- IDLE: no request -> stay. One request -> grant it. Both -> grant the requester not granted last. On grant, latch the owner's wr, iom, addr and wdata, then go to T1. Fields change only at grant.
- T1: ALE=1, CS=1, gnt[owner]=1, Address/IOM valid. Next state T2.
- T2: ALE=0. Read: RD=0. Write: WR=0, data_oe=1, Data_out valid. Next state T3.
- T3: strobes held. READY high at the closing edge -> T4; otherwise -> TW with wait counter = 1.
- TW: strobes held. READY high -> T4. Otherwise, if the counter equals MAX_WAIT -> T4 with err set; else increment the counter.
- Read data: rdata <= Data_in at the edge leaving T3 or TW with READY high. A timed-out read leaves rdata unchanged.
- T4: RD=1, WR=1, data_oe=0, CS=1, done[owner]=1, err as determined. The last-owner pointer updates to the owner. Next state IDLE; the wait counter clears.
- Deasserting req mid-cycle has no effect; the cycle completes and done still pulses.
- The arbiter does not grant a requester that is not requesting, and never grants both.

## Timing
- Request sampled in IDLE at edge e0. T1 occupies e0 to e1, T2 e1 to e2, T3 e2 to e3, T4 e3 to e4, then IDLE.
- Zero-wait transaction: gnt 1 cycle after the req edge, done 3 cycles after gnt; 5 cycles per transaction including the mandatory IDLE.
- Each TW adds exactly 1 cycle. Worst case is 5 + MAX_WAIT cycles.
- Back-to-back requests from both requesters alternate 0,1,0,1 with one IDLE between cycles.
- Reset asserted in any state returns all strobes to inactive combinationally through the async reset. No done pulse is issued for the aborted cycle.

## Test plan
- Single read, READY=1: req[0], addr 0x12345, iom=1, slave returns 0xA5 -> ALE in T1 only, RD low T2–T3, done[0] 4 cycles after req edge, rdata=0xA5, err=0.
- Single write with 2 waits: req[1], addr 0xFFFFF, wdata 0x3C, READY low for 2 cycles -> WR low T2, T3, TW, TW; data_oe matches; done[1] 6 cycles after req; err=0.
- Timeout: READY held low, MAX_WAIT=15 -> 15 TW cycles, done with err=1, rdata unchanged from its previous value 0xA5.
- Contention: req=2'b11 held for 4 transactions after reset -> grant order 0,1,0,1, gnt always one-hot, 5-cycle spacing.
- Request drop: req[0] deasserted in T2 -> cycle still completes, done[0] pulses, next grant goes to requester 1 if it is requesting.
- Reset mid-cycle: RESET low during TW of a write -> WR=1, CS=0, data_oe=0 immediately; after release, the next request from requester 0 wins.
